// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave that answers like a PmodJSTK: a 5-byte frame of X/Y/buttons out,
// with the first byte the master sends decoded as an LED command.
module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic       miso,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int FRAME_BITS = FRAME_BYTES * 8;
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [5:0] FULL_CNT = 6'(FRAME_BITS);
    localparam logic [5:0] CMD_BIT  = 6'd7;
    localparam logic [5:0] CMD_TAG  = 6'b100000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        OVERRUN = 2'd3
    } state_e;

    state_e state;
    state_e state_next;

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_d;
    logic                   sclk_d;
    logic                   ss_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   sclk_rise;
    logic                   sclk_fall;

    logic [39:0] tx;
    logic [39:0] snapshot;
    logic [7:0]  rx;
    logic [7:0]  rx_new;
    logic [5:0]  cnt;

    logic load;
    logic rx_shift;
    logic tx_shift;
    logic led_we;
    logic done_p;
    logic err_p;
    logic miso_next;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    assign snapshot = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, btn};
    assign rx_new   = {rx[6:0], mosi_s};

    // Synchronizers reset to the bus idle levels so reset never looks like an ss edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        rx_shift   = 1'b0;
        tx_shift   = 1'b0;
        led_we     = 1'b0;
        done_p     = 1'b0;
        err_p      = 1'b0;
        miso_next  = miso;

        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load      = 1'b1;
                miso_next = snapshot[39];
                state_next = ss_rise ? IDLE : SHIFT;
            end
            SHIFT, OVERRUN: begin
                // An ss rise beats any sclk edge seen in the same cycle.
                if (ss_rise) begin
                    state_next = IDLE;
                    done_p     = (cnt == FULL_CNT);
                    err_p      = (cnt != 6'd0) && (cnt < FULL_CNT);
                end else if (state == SHIFT) begin
                    if (sclk_rise) begin
                        rx_shift = 1'b1;
                        if (cnt == LAST_BIT) begin
                            state_next = OVERRUN;
                        end
                        if ((cnt == CMD_BIT) && (rx_new[7:2] == CMD_TAG)) begin
                            led_we = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_shift  = 1'b1;
                        miso_next = tx[38];
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if ((state_next == IDLE) || (state_next == OVERRUN)) begin
            miso_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx         <= '0;
            rx         <= '0;
            cnt        <= '0;
            miso       <= 1'b0;
            led        <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            miso       <= miso_next;
            frame_done <= done_p;
            frame_err  <= err_p;
            busy       <= (state_next == SHIFT) || (state_next == OVERRUN);
            if (load) begin
                tx  <= snapshot;
                cnt <= '0;
            end
            if (rx_shift) begin
                rx  <= rx_new;
                cnt <= cnt + 6'd1;
            end
            if (tx_shift) begin
                tx <= {tx[38:0], 1'b0};
            end
            // Only the first byte of a frame can carry an LED command.
            if (led_we) begin
                led <= rx_new[1:0];
            end
        end
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: an SPI master drives frames at sclk = clk/10,
// returned bytes and frame-end pulses are checked against queued expectations.
module tb_jstk_spi_responder;

    logic       clk;
    logic       rst;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] btn;
    logic       miso;
    logic [1:0] led;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit stim_done = 0;

    // Expected/actual byte streams and expected frame-end events (1=done, 2=err).
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    logic [1:0] exp_evt_q[$];

    jstk_spi_responder #(
        .SYNC_STAGES(2),
        .FRAME_BYTES(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .sclk      (sclk),
        .mosi      (mosi),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .btn       (btn),
        .miso      (miso),
        .led       (led),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input logic [39:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(bytes[39-8*i -: 8]);
        end
    endtask

    // Master driver. hook_kind 1 switches x_pos to 3FF, 2 resets the DUT and ends the frame.
    task automatic spi_frame(input logic [47:0] mbits, input int nbits,
                             input int hook_bit, input int hook_kind);
        logic [7:0] cur;
        cur = 8'h00;
        ss = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_mid_frame", 32'(busy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == hook_bit && hook_kind == 1) begin
                x_pos = 10'h3FF;
            end
            if (i == hook_bit && hook_kind == 2) begin
                rst  = 1'b1;
                ss   = 1'b1;
                mosi = 1'b0;
                repeat (3) @(negedge clk);
                check("rst_mid_miso", 32'(miso), 32'd0);
                check("rst_mid_busy", 32'(busy), 32'd0);
                check("rst_mid_led", 32'(led), 32'd0);
                rst = 1'b0;
                repeat (10) @(negedge clk);
                check("post_rst_busy", 32'(busy), 32'd0);
                return;
            end
            mosi = mbits[47-i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            cur  = {cur[6:0], miso};
            if (i % 8 == 7) begin
                act_q.push_back(cur);
            end
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        ss = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (act_q.size() > 0) begin
            logic [7:0] a;
            a = act_q.pop_front();
            if (exp_q.size() == 0) begin
                check("miso_byte_unexpected", 32'(a), 32'hFFFF_FFFF);
            end else begin
                check("miso_byte", 32'(a), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (frame_done || frame_err)) begin
            logic [1:0] code;
            code = {frame_err, frame_done};
            if (exp_evt_q.size() == 0) begin
                check("frame_event_unexpected", 32'(code), 32'd0);
            end else begin
                check("frame_event", 32'(code), 32'(exp_evt_q.pop_front()));
            end
        end
    end

    // Stimulus
    initial begin
        rst   = 1'b1;
        ss    = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        x_pos = 10'h2A5;
        y_pos = 10'h0F0;
        btn   = 3'b101;
        repeat (4) @(negedge clk);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_led", 32'(led), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pulses", 32'({frame_done, frame_err}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: full frame with LED command 0x83
        push_bytes(40'hA5_02_F0_00_05, 5);
        exp_evt_q.push_back(2'd1);
        spi_frame({8'h83, 40'h0}, 40, -1, 0);
        check("t1_led", 32'(led), 32'd3);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: non-command first byte leaves led alone
        push_bytes(40'hA5_02_F0_00_05, 5);
        exp_evt_q.push_back(2'd1);
        spi_frame({8'h40, 40'h0}, 40, -1, 0);
        check("t2_led", 32'(led), 32'd3);

        // 3: x_pos changes mid-frame; only the next frame sees it
        x_pos = 10'h000;
        btn   = 3'b000;
        push_bytes(40'h00_00_F0_00_00, 5);
        exp_evt_q.push_back(2'd1);
        spi_frame(48'h0, 40, 1, 1);
        push_bytes(40'hFF_03_F0_00_00, 5);
        exp_evt_q.push_back(2'd1);
        spi_frame(48'h0, 40, -1, 0);
        check("t3_led", 32'(led), 32'd3);

        // 4: abort after 12 bits, command byte 0x82 still applies
        push_bytes(40'hFF_00_00_00_00, 1);
        exp_evt_q.push_back(2'd2);
        spi_frame({8'h82, 40'h0}, 12, -1, 0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_led", 32'(led), 32'd2);
        push_bytes(40'hFF_03_F0_00_00, 5);
        exp_evt_q.push_back(2'd1);
        spi_frame({8'h81, 40'h0}, 40, -1, 0);
        check("t4_next_led", 32'(led), 32'd1);

        // 5: overrun, 48 clocks; bits 41..48 read as zero
        push_bytes(40'hFF_03_F0_00_00, 5);
        exp_q.push_back(8'h00);
        exp_evt_q.push_back(2'd1);
        spi_frame(48'h0, 48, -1, 0);
        check("t5_led", 32'(led), 32'd1);

        // 6: reset at bit 20, then a clean frame
        btn = 3'b010;
        push_bytes(40'hFF_03_00_00_00, 2);
        spi_frame({8'h83, 40'h0}, 40, 20, 2);
        push_bytes(40'hFF_03_F0_00_02, 5);
        exp_evt_q.push_back(2'd1);
        spi_frame(48'h0, 40, -1, 0);
        check("t6_led", 32'(led), 32'd0);

        repeat (20) @(negedge clk);
        check("exp_bytes_drained", 32'(exp_q.size()), 32'd0);
        check("act_bytes_drained", 32'(act_q.size()), 32'd0);
        check("events_drained", 32'(exp_evt_q.size()), 32'd0);
        stim_done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jstk_spi_responder.md
Name: jstk_spi_responder

Overview:
- SPI slave model of the PmodJSTK joystick, the responder end of the SPI link used by the joystick-direction path.
- Serves a 5-byte frame built from supplied X/Y positions and button state, and decodes the master's LED command byte.
- Lets the game's direction logic run in simulation and on boards without the physical Pmod, with positions driven from switches or a testbench.
- Runs in the 100 MHz system clock domain and oversamples ss/sclk/mosi.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on ss, sclk and mosi (min 2).
- FRAME_BYTES, 5: bytes per frame. Fixed protocol value; only 5 is supported.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset
- ss  in  1  slave select from master, active low
- sclk  in  1  SPI clock from master, mode 0, idle low, max clk/8
- mosi  in  1  master-out data
- x_pos  in  10  X position, 0..1023
- y_pos  in  10  Y position, 0..1023
- btn  in  3  buttons {btn2, btn1, trigger}
- miso  out  1  slave-out data
- led  out  2  LED state from the last valid command byte
- frame_done  out  1  one-cycle pulse when a full 40-bit frame ends
- frame_err  out  1  one-cycle pulse when ss rises before 40 bits
- busy  out  1  high while a frame is active

Behaviour:
- Reset: rst is synchronous, active-high.
  - On reset: miso=0, led=2'b00, frame_done=0, frame_err=0, busy=0, bit counter=0, state IDLE, synchronizers cleared to ss=1, sclk=0, mosi=0.
  - Reset mid-frame aborts the frame with no frame_err pulse.
- Input sync and edge detect:
  - ss, sclk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized values by comparing against one more registered copy.
- State machine: IDLE, LOAD, SHIFT, OVERRUN.
  - IDLE -> LOAD on the synchronized ss falling edge.
  - LOAD lasts 1 cycle:
    - Snapshots the tx register, transmitted in this byte order: {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, btn}.
    - Drives miso = tx[39], clears the bit counter, sets busy.
    - Goes to SHIFT.
  - SHIFT:
    - On sclk rising edge: shift mosi into the 8-bit rx register and increment the bit counter (0..40).
    - On sclk falling edge: shift tx left and drive miso = new tx[39].
    - When the counter reaches 40, go to OVERRUN.
  - OVERRUN: miso=0; further sclk edges are ignored.
  - From SHIFT or OVERRUN, an ss rising edge returns to IDLE and clears busy.
- Frame end on ss rising edge:
  - Counter == 40: frame_done pulses for 1 cycle.
  - 0 < counter < 40: frame_err pulses for 1 cycle.
  - Counter == 0: no pulse.
- Command decode:
  - When the counter reaches 8, check the command byte rx[7:0].
  - If rx[7:2] == 6'b100000, then led <= rx[1:0] on the same cycle. Otherwise led is unchanged.
  - Command bytes in bytes 2..5 are ignored.
  - The LED update stands even if the frame later aborts.
- Data stability:
  - x_pos, y_pos and btn changes during a frame do not affect the frame in progress; the snapshot is taken only in LOAD.
- miso while idle: held 0 in IDLE.
- Timing:
  - First miso bit is valid SYNC_STAGES+2 clk cycles after ss falls at the pin.
  - Master must allow at least 1 µs between ss falling and the first sclk rise (PmodJSTK masters use 15 µs).
  - miso changes at most SYNC_STAGES+2 clk cycles after sclk falls at the pin, which stays inside the half period at sclk ≤ clk/8.
- Simultaneous events:
  - ss rising in the same cycle as an sclk edge: the ss edge wins and the sclk edge is discarded.
  - ss falling while in LOAD cannot occur, since ss must have risen first.
- Glitches:
  - A ss low pulse shorter than SYNC_STAGES+1 cycles may be missed entirely.
  - A detected low pulse with no sclk activity returns to IDLE with no pulse.

Test Plan:
1. Full frame: x_pos=10'h2A5, y_pos=10'h0F0, btn=3'b101; master sends 0x83,0,0,0,0 at sclk=clk/10.
   -> master receives A5 02 F0 00 05, led=2'b11, frame_done pulses once, frame_err never asserts.
2. Non-command first byte: master sends 0x40 with led previously 2'b11.
   -> led stays 2'b11; returned data is correct; frame_done pulses.
3. Change x_pos from 10'h000 to 10'h3FF after the first sclk edge.
   -> this frame returns 00 00 for X; the next frame returns FF 03.
4. Abort: ss rises after 12 bits.
   -> frame_err pulses 1 cycle, busy=0, led is updated from byte 1 if it was a command; the next frame starts cleanly from byte 1.
5. Overrun: 48 sclk cycles within one ss low.
   -> bits 41-48 on miso read 0; frame_done pulses on ss rise.
6. Reset mid-frame: assert rst at bit 20.
   -> miso=0, busy=0, led=0, no pulses; the next full frame is correct.
